arbitro_demux_dest: RTL and testbench
=====================================

ARBITRO_DEMUX_DEST -- requirements
Module: arbitro_demux_dest

Interface
REQ-001 SHALL have parameter DATA_W, default 6: width of every data word.
REQ-002 SHALL have parameter DEST_BIT, default 4: index of the word bit that selects the destination (0 = D0, 1 = D1).
REQ-003 SHALL have parameter CNT_W, default 5: width of each push counter.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_L, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports pop_delay_VC0 and pop_delay_VC1, input, 1 each: the word on the matching data input is valid this cycle.
REQ-007 SHALL have ports data_arbitro_VC0 and data_arbitro_VC1, input, DATA_W each: word read from VC0 / VC1.
REQ-008 SHALL have ports full_fifo_D0 and full_fifo_D1, input, 1 each: destination FIFO full.
REQ-009 SHALL have ports push_D0 and push_D1, output, 1 each: write strobes to the destination FIFOs.
REQ-010 SHALL have ports data_D0 and data_D1, output, DATA_W each: words written to the destination FIFOs.
REQ-011 SHALL have ports contador_D0 and contador_D1, output, CNT_W each: count of accepted pushes per destination.
REQ-012 SHALL have port error_drop, output, 1: one-cycle pulse when a word is discarded.
REQ-013 SHALL have port idle, output, 1: high when no word is held and no push is pending.

Function
REQ-014 Input select SHALL be: word = data_arbitro_VC0 if pop_delay_VC0, else data_arbitro_VC1 if pop_delay_VC1; valid = pop_delay_VC0 | pop_delay_VC1.
REQ-015 Both pop_delay inputs high in the same cycle SHALL forward the VC0 word, discard the VC1 word, and pulse error_drop.
REQ-016 The destination SHALL be word[DEST_BIT].
REQ-017 Each destination SHALL have a two-state FSM: PASS and HOLD.
REQ-018 In PASS with a valid word for destination d and full_fifo_Dd = 0: push_Dd = 1 and data_Dd = word on the next cycle, so latency is 1 cycle.
REQ-019 In PASS with a valid word for d and full_fifo_Dd = 1: the word SHALL be stored in hold register d and the FSM SHALL move to HOLD; no push.
REQ-020 In HOLD with full_fifo_Dd = 0: the held word SHALL be pushed next cycle, and the FSM SHALL return to PASS unless a new word for d arrives in the same cycle.
REQ-021 In HOLD with a new word for d arriving: if full_fifo_Dd = 0, push the held word and load the new word into hold (stay in HOLD); if full_fifo_Dd = 1, discard the new word and pulse error_drop.
REQ-022 Words for the other destination SHALL proceed independently; a held word SHALL never block the other destination.
REQ-023 push_Dd SHALL be registered and high for exactly one cycle per accepted word; data_Dd SHALL hold its last value when push_Dd = 0.
REQ-024 contador_Dd SHALL increment on every cycle with push_Dd = 1 and wrap from 2^CNT_W-1 to 0.
REQ-025 idle SHALL equal: both FSMs in PASS, both push strobes low, and valid low.

Reset
REQ-026 reset_L low SHALL asynchronously set push_D0 = push_D1 = 0, data_D0 = data_D1 = 0, contador_D0 = contador_D1 = 0, error_drop = 0, both FSMs to PASS, hold registers to 0, and idle to 1.
REQ-027 Reset asserted mid-operation SHALL discard held words without pushing them or pulsing error_drop.
REQ-028 The first push SHALL occur no earlier than the second rising clk edge after reset_L deasserts.

Structure
REQ-029 A shared package SHALL define the DATA_W, DEST_BIT and CNT_W defaults and the PASS/HOLD state encoding.
REQ-030 The per-destination FSM, hold register, push strobe and counter SHALL be one sub-module, retencion_dest, instantiated twice.

Verification
REQ-031 Scenario: reset, then pop_delay_VC0 = 1 with data 6'h05 (bit4 = 0), fulls low -> next cycle push_D0 = 1, data_D0 = 05, contador_D0 = 1; push_D1 = 0.
REQ-032 Scenario: pop_delay_VC1 = 1 with data 6'h13, full_fifo_D1 = 1 for 3 cycles -> no push while full; push_D1 = 1 with data 13 one cycle after full drops; idle = 0 while held.
REQ-033 Scenario: D1 word held, then word 6'h1A arrives with full_fifo_D1 still 1 -> error_drop pulses once; the held word is pushed later; 1A is never pushed.
REQ-034 Scenario: D1 word held, then word 6'h02 arrives for D0, full_fifo_D0 = 0 -> push_D0 with 02 next cycle, unaffected by the D1 hold.
REQ-035 Scenario: both pop_delay inputs high, VC0 = 6'h01, VC1 = 6'h11 -> push_D0 with 01, error_drop = 1, no push_D1.
REQ-036 Scenario: 33 back-to-back D0 words with CNT_W = 5, then reset_L pulsed low mid-hold -> contador_D0 reads 1 after wrap; after reset all outputs = 0, idle = 1.

Source files
------------

// File: rtl/arbitro_demux_dest_pkg.sv
// Shared definitions for the VC-to-destination demultiplexer:
// parameter defaults, the destination count and the PASS/HOLD state encoding.
package arbitro_demux_dest_pkg;

    // Default geometry of the datapath
    localparam int DATA_W_DEF   = 6;
    localparam int DEST_BIT_DEF = 4;
    localparam int CNT_W_DEF    = 5;

    // Two destination FIFOs, D0 and D1
    localparam int NUM_DEST = 2;

    // Per-destination FSM encoding (kept as plain constants for legacy tools)
    localparam logic [0:0] ST_PASS = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage : arbitro_demux_dest_pkg

// File: rtl/arbitro_demux_dest_if.sv
// Bundle of the VC-side inputs and destination-side outputs of the demux.
// The slave modport is the demux itself; the master modport is whoever
// drives the virtual channels and watches the destination FIFOs.
interface arbitro_demux_dest_if
    import arbitro_demux_dest_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);

    // Virtual-channel side
    logic              pop_delay_VC0;
    logic              pop_delay_VC1;
    logic [DATA_W-1:0] data_arbitro_VC0;
    logic [DATA_W-1:0] data_arbitro_VC1;

    // Destination FIFO back-pressure
    logic              full_fifo_D0;
    logic              full_fifo_D1;

    // Destination FIFO write side
    logic              push_D0;
    logic              push_D1;
    logic [DATA_W-1:0] data_D0;
    logic [DATA_W-1:0] data_D1;

    // Status
    logic [CNT_W-1:0]  contador_D0;
    logic [CNT_W-1:0]  contador_D1;
    logic              error_drop;
    logic              idle;

    modport slave (
        input  pop_delay_VC0, pop_delay_VC1,
        input  data_arbitro_VC0, data_arbitro_VC1,
        input  full_fifo_D0, full_fifo_D1,
        output push_D0, push_D1,
        output data_D0, data_D1,
        output contador_D0, contador_D1,
        output error_drop, idle
    );

    modport master (
        output pop_delay_VC0, pop_delay_VC1,
        output data_arbitro_VC0, data_arbitro_VC1,
        output full_fifo_D0, full_fifo_D1,
        input  push_D0, push_D1,
        input  data_D0, data_D1,
        input  contador_D0, contador_D1,
        input  error_drop, idle
    );

endinterface : arbitro_demux_dest_if

// File: rtl/arbitro_demux_dest_retencion_dest.sv
// One destination lane: a PASS/HOLD FSM with a single-word hold register,
// a registered push strobe with its data word, and a wrapping push counter.
// A word that arrives while the lane already holds one and the FIFO is
// still full cannot be kept; it is reported on drop for one cycle.
module retencion_dest
    import arbitro_demux_dest_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              full,
    output logic              push,
    output logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  contador,
    output logic              drop,
    output logic              in_pass
);

    logic [0:0]        state_reg,  state_next;
    logic [DATA_W-1:0] hold_reg,   hold_next;
    logic              push_reg,   push_next;
    logic [DATA_W-1:0] data_reg,   data_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic              drop_next;

    // Next-state logic: decide whether to push, park or discard this cycle
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        push_next  = 1'b0;
        data_next  = data_reg;
        drop_next  = 1'b0;

        case (state_reg)
            ST_PASS: begin
                if (in_valid) begin
                    if (!full) begin
                        // Straight through, one cycle of latency
                        push_next = 1'b1;
                        data_next = in_data;
                    end else begin
                        // FIFO full: park the word until space appears
                        hold_next  = in_data;
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!full) begin
                    // Space available: drain the parked word first
                    push_next = 1'b1;
                    data_next = hold_reg;
                    if (in_valid) begin
                        // New word takes the freed slot, lane stays parked
                        hold_next = in_data;
                    end else begin
                        state_next = ST_PASS;
                    end
                end else if (in_valid) begin
                    // Slot occupied and FIFO still full: nowhere to keep it
                    drop_next = 1'b1;
                end
            end
        endcase
    end

    // Counter follows the push strobe so both update on the same edge
    always_comb begin
        cnt_next = cnt_reg;
        if (push_next) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // State, hold, strobe, data and counter registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg <= ST_PASS;
            hold_reg  <= '0;
            push_reg  <= 1'b0;
            data_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            push_reg  <= push_next;
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign push     = push_reg;
    assign data     = data_reg;
    assign contador = cnt_reg;
    assign drop     = drop_next;
    assign in_pass  = (state_reg == ST_PASS);

endmodule : retencion_dest

// File: rtl/arbitro_demux_dest.sv
// Demultiplexer from two virtual channels to two destination FIFOs.
// VC0 wins when both channels present a word in the same cycle; the VC1
// word is then discarded and error_drop pulses. The destination is taken
// from a single bit of the word, and each destination has its own lane so
// a parked word on one side never stalls the other.
module arbitro_demux_dest
    import arbitro_demux_dest_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEST_BIT = DEST_BIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_L,
    arbitro_demux_dest_if.slave  bus
);

    logic              run_reg;
    logic              valid_raw;
    logic              valid_acc;
    logic              both_pop;
    logic [DATA_W-1:0] word;
    logic              dest_sel;
    logic              error_drop_reg;

    logic [NUM_DEST-1:0] lane_valid;
    logic [NUM_DEST-1:0] lane_full;
    logic [NUM_DEST-1:0] lane_push;
    logic [NUM_DEST-1:0] lane_drop;
    logic [NUM_DEST-1:0] lane_pass;
    logic [DATA_W-1:0]   lane_data [NUM_DEST];
    logic [CNT_W-1:0]    lane_cnt  [NUM_DEST];

    // Inputs are ignored on the first edge after reset release, so the
    // earliest push appears on the second edge
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    // Channel select: VC0 has priority over VC1
    always_comb begin
        valid_raw = bus.pop_delay_VC0 | bus.pop_delay_VC1;
        valid_acc = valid_raw & run_reg;
        both_pop  = bus.pop_delay_VC0 & bus.pop_delay_VC1 & run_reg;
        word      = bus.pop_delay_VC0 ? bus.data_arbitro_VC0 : bus.data_arbitro_VC1;
        dest_sel  = word[DEST_BIT];
    end

    assign lane_full[0] = bus.full_fifo_D0;
    assign lane_full[1] = bus.full_fifo_D1;

    // One lane per destination, steered by the destination bit
    generate
        for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_lane
            localparam logic LANE_ID = 1'(gi);

            assign lane_valid[gi] = valid_acc & (dest_sel == LANE_ID);

            retencion_dest #(
                .DATA_W (DATA_W),
                .CNT_W  (CNT_W)
            ) u_retencion_dest (
                .clk      (clk),
                .reset_L  (reset_L),
                .in_valid (lane_valid[gi]),
                .in_data  (word),
                .full     (lane_full[gi]),
                .push     (lane_push[gi]),
                .data     (lane_data[gi]),
                .contador (lane_cnt[gi]),
                .drop     (lane_drop[gi]),
                .in_pass  (lane_pass[gi])
            );
        end
    endgenerate

    // Any discarded word this cycle shows as a one-cycle pulse, aligned
    // with the push that results from the same input cycle
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            error_drop_reg <= 1'b0;
        end else begin
            error_drop_reg <= both_pop | (|lane_drop);
        end
    end

    assign bus.push_D0     = lane_push[0];
    assign bus.push_D1     = lane_push[1];
    assign bus.data_D0     = lane_data[0];
    assign bus.data_D1     = lane_data[1];
    assign bus.contador_D0 = lane_cnt[0];
    assign bus.contador_D1 = lane_cnt[1];
    assign bus.error_drop  = error_drop_reg;
    assign bus.idle        = (&lane_pass) & ~(|lane_push) & ~valid_raw;

endmodule : arbitro_demux_dest

// File: tb/tb_arbitro_demux_dest.sv
// Directed bench for arbitro_demux_dest: reset behaviour, pass-through,
// hold on full, drop on overflow, lane independence, VC collision,
// hold reload and counter wrap with a mid-hold reset.
`timescale 1ns/1ps
module tb_arbitro_demux_dest;

    localparam int DATA_W   = 6;
    localparam int DEST_BIT = 4;
    localparam int CNT_W    = 5;

    logic clk;
    logic reset_L;
    int   n_cmp;
    int   n_bad;
    int   cyc;

    arbitro_demux_dest_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    arbitro_demux_dest #(
        .DATA_W   (DATA_W),
        .DEST_BIT (DEST_BIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic p0, input logic p1,
                         input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                         input logic f0, input logic f1);
        bus.pop_delay_VC0    = p0;
        bus.pop_delay_VC1    = p1;
        bus.data_arbitro_VC0 = d0;
        bus.data_arbitro_VC1 = d1;
        bus.full_fifo_D0     = f0;
        bus.full_fifo_D1     = f1;
    endtask

    // Advance one rising edge and settle just after it; one line per cycle
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d: push0=%0b d0=%h c0=%0d push1=%0b d1=%h c1=%0d err=%0b idle=%0b",
                 cyc, bus.push_D0, bus.data_D0, bus.contador_D0, bus.push_D1,
                 bus.data_D1, bus.contador_D1, bus.error_drop, bus.idle);
    endtask

    task automatic apply_reset();
        drive(0, 0, '0, '0, 0, 0);
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        drive(0, 0, '0, '0, 0, 0);
        reset_L = 1'b0;
        #1;
        n_cmp++;
        if ({bus.push_D0, bus.push_D1, bus.error_drop, bus.idle} !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_flags: got %b need 0001", {bus.push_D0, bus.push_D1, bus.error_drop, bus.idle});
        end
        tick();
        tick();
        n_cmp++;
        if ({bus.data_D0, bus.data_D1} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_data: got %h need 000", {bus.data_D0, bus.data_D1});
        end
        n_cmp++;
        if ({bus.contador_D0, bus.contador_D1} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %h need 000", {bus.contador_D0, bus.contador_D1});
        end
        // Release mid-cycle with a word already waiting
        #3;
        reset_L = 1'b1;
        drive(1, 0, 6'h07, '0, 0, 0);
        tick();
        n_cmp++;
        if (bus.push_D0 !== 1'b0) begin
            n_bad++;
            $display("FAIL first_edge_push: got %b need 0", bus.push_D0);
        end
        tick();
        n_cmp++;
        if ({bus.push_D0, bus.data_D0} !== {1'b1, 6'h07}) begin
            n_bad++;
            $display("FAIL second_edge_push: got %b/%h need 1/07", bus.push_D0, bus.data_D0);
        end
        drive(0, 0, '0, '0, 0, 0);
        tick();
    endtask

    task automatic test_pass_d0();
        apply_reset();
        drive(1, 0, 6'h05, '0, 0, 0);
        tick();
        n_cmp++;
        if ({bus.push_D0, bus.data_D0, bus.contador_D0, bus.push_D1} !== {1'b1, 6'h05, 5'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL pass_d0: got push0=%b d0=%h c0=%0d push1=%b need 1/05/1/0",
                     bus.push_D0, bus.data_D0, bus.contador_D0, bus.push_D1);
        end
        drive(0, 0, '0, '0, 0, 0);
        tick();
        n_cmp++;
        if ({bus.push_D0, bus.data_D0, bus.idle} !== {1'b0, 6'h05, 1'b1}) begin
            n_bad++;
            $display("FAIL pass_d0_after: got push0=%b d0=%h idle=%b need 0/05/1",
                     bus.push_D0, bus.data_D0, bus.idle);
        end
    endtask

    task automatic test_hold_d1();
        drive(0, 1, '0, 6'h13, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(0, 0, '0, '0, 0, 1);
            n_cmp++;
            if ({bus.push_D1, bus.idle} !== 2'b00) begin
                n_bad++;
                $display("FAIL hold_d1_wait%0d: got push1=%b idle=%b need 0/0", i, bus.push_D1, bus.idle);
            end
        end
        drive(0, 0, '0, '0, 0, 0);
        tick();
        n_cmp++;
        if ({bus.push_D1, bus.data_D1, bus.contador_D1} !== {1'b1, 6'h13, 5'd1}) begin
            n_bad++;
            $display("FAIL hold_d1_release: got push1=%b d1=%h c1=%0d need 1/13/1",
                     bus.push_D1, bus.data_D1, bus.contador_D1);
        end
        tick();
        n_cmp++;
        if ({bus.push_D1, bus.idle} !== 2'b01) begin
            n_bad++;
            $display("FAIL hold_d1_idle: got push1=%b idle=%b need 0/1", bus.push_D1, bus.idle);
        end
    endtask

    task automatic test_drop_held();
        drive(0, 1, '0, 6'h15, 0, 1);
        tick();
        drive(0, 1, '0, 6'h1A, 0, 1);
        tick();
        n_cmp++;
        if ({bus.error_drop, bus.push_D1} !== 2'b10) begin
            n_bad++;
            $display("FAIL drop_pulse: got err=%b push1=%b need 1/0", bus.error_drop, bus.push_D1);
        end
        drive(0, 0, '0, '0, 0, 1);
        tick();
        n_cmp++;
        if (bus.error_drop !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_single: got err=%b need 0", bus.error_drop);
        end
        drive(0, 0, '0, '0, 0, 0);
        tick();
        n_cmp++;
        if ({bus.push_D1, bus.data_D1, bus.contador_D1} !== {1'b1, 6'h15, 5'd2}) begin
            n_bad++;
            $display("FAIL drop_held_push: got push1=%b d1=%h c1=%0d need 1/15/2",
                     bus.push_D1, bus.data_D1, bus.contador_D1);
        end
        tick();
        n_cmp++;
        if ({bus.push_D1, bus.data_D1, bus.contador_D1, bus.idle} !== {1'b0, 6'h15, 5'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL drop_never_pushed: got push1=%b d1=%h c1=%0d idle=%b need 0/15/2/1",
                     bus.push_D1, bus.data_D1, bus.contador_D1, bus.idle);
        end
    endtask

    task automatic test_independent();
        drive(0, 1, '0, 6'h1C, 0, 1);
        tick();
        drive(1, 0, 6'h02, '0, 0, 1);
        tick();
        n_cmp++;
        if ({bus.push_D0, bus.data_D0, bus.contador_D0, bus.push_D1} !== {1'b1, 6'h02, 5'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL indep_d0: got push0=%b d0=%h c0=%0d push1=%b need 1/02/2/0",
                     bus.push_D0, bus.data_D0, bus.contador_D0, bus.push_D1);
        end
        drive(0, 0, '0, '0, 0, 0);
        tick();
        n_cmp++;
        if ({bus.push_D0, bus.push_D1, bus.data_D1, bus.contador_D1} !== {1'b0, 1'b1, 6'h1C, 5'd3}) begin
            n_bad++;
            $display("FAIL indep_d1: got push0=%b push1=%b d1=%h c1=%0d need 0/1/1c/3",
                     bus.push_D0, bus.push_D1, bus.data_D1, bus.contador_D1);
        end
        tick();
    endtask

    task automatic test_both_pop();
        drive(1, 1, 6'h01, 6'h11, 0, 0);
        tick();
        n_cmp++;
        if ({bus.push_D0, bus.data_D0, bus.error_drop, bus.push_D1, bus.contador_D0} !==
            {1'b1, 6'h01, 1'b1, 1'b0, 5'd3}) begin
            n_bad++;
            $display("FAIL both_pop: got push0=%b d0=%h err=%b push1=%b c0=%0d need 1/01/1/0/3",
                     bus.push_D0, bus.data_D0, bus.error_drop, bus.push_D1, bus.contador_D0);
        end
        drive(0, 0, '0, '0, 0, 0);
        tick();
        n_cmp++;
        if ({bus.error_drop, bus.push_D0, bus.push_D1} !== 3'b000) begin
            n_bad++;
            $display("FAIL both_pop_after: got err=%b push0=%b push1=%b need 0/0/0",
                     bus.error_drop, bus.push_D0, bus.push_D1);
        end
    endtask

    task automatic test_hold_reload();
        drive(0, 1, '0, 6'h12, 0, 1);
        tick();
        drive(0, 1, '0, 6'h1F, 0, 0);
        tick();
        n_cmp++;
        if ({bus.push_D1, bus.data_D1, bus.contador_D1, bus.error_drop} !== {1'b1, 6'h12, 5'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL reload_first: got push1=%b d1=%h c1=%0d err=%b need 1/12/4/0",
                     bus.push_D1, bus.data_D1, bus.contador_D1, bus.error_drop);
        end
        drive(0, 0, '0, '0, 0, 0);
        tick();
        n_cmp++;
        if ({bus.push_D1, bus.data_D1, bus.contador_D1} !== {1'b1, 6'h1F, 5'd5}) begin
            n_bad++;
            $display("FAIL reload_second: got push1=%b d1=%h c1=%0d need 1/1f/5",
                     bus.push_D1, bus.data_D1, bus.contador_D1);
        end
        tick();
        n_cmp++;
        if ({bus.push_D1, bus.idle} !== 2'b01) begin
            n_bad++;
            $display("FAIL reload_idle: got push1=%b idle=%b need 0/1", bus.push_D1, bus.idle);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] w;
        logic [CNT_W-1:0]  exp_cnt;
        apply_reset();
        for (int i = 0; i < 33; i++) begin
            // Keep bit 4 clear so every word targets D0
            w = DATA_W'((i % 16) + ((i / 16) % 2) * 32);
            drive(1, 0, w, '0, 0, 0);
            tick();
            exp_cnt = CNT_W'((i + 1) % 32);
            n_cmp++;
            if ({bus.push_D0, bus.data_D0, bus.contador_D0} !== {1'b1, w, exp_cnt}) begin
                n_bad++;
                $display("FAIL b2b_word%0d: got push0=%b d0=%h c0=%0d need 1/%h/%0d",
                         i, bus.push_D0, bus.data_D0, bus.contador_D0, w, exp_cnt);
            end
        end
        // Park a word, then reset while it is held
        drive(1, 0, 6'h03, '0, 1, 0);
        tick();
        n_cmp++;
        if ({bus.push_D0, bus.contador_D0, bus.idle} !== {1'b0, 5'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_parked: got push0=%b c0=%0d idle=%b need 0/1/0",
                     bus.push_D0, bus.contador_D0, bus.idle);
        end
        drive(0, 0, '0, '0, 1, 0);
        #2;
        reset_L = 1'b0;
        #1;
        n_cmp++;
        if ({bus.push_D0, bus.push_D1, bus.data_D0, bus.data_D1, bus.contador_D0,
             bus.contador_D1, bus.error_drop, bus.idle} !== {2'b00, 12'h000, 10'd0, 2'b01}) begin
            n_bad++;
            $display("FAIL midhold_reset: got p0=%b p1=%b d0=%h d1=%h c0=%0d c1=%0d err=%b idle=%b",
                     bus.push_D0, bus.push_D1, bus.data_D0, bus.data_D1, bus.contador_D0,
                     bus.contador_D1, bus.error_drop, bus.idle);
        end
        tick();
        drive(0, 0, '0, '0, 0, 0);
        reset_L = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.push_D0, bus.contador_D0, bus.error_drop, bus.idle} !== {1'b0, 5'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL held_discarded: got push0=%b c0=%0d err=%b idle=%b need 0/0/0/1",
                     bus.push_D0, bus.contador_D0, bus.error_drop, bus.idle);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        reset_L = 1'b0;
        drive(0, 0, '0, '0, 0, 0);
        test_reset();
        test_pass_d0();
        test_hold_d1();
        test_drop_held();
        test_independent();
        test_both_pop();
        test_hold_reload();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_arbitro_demux_dest
